// File: rtl/xge_tx_arbiter.sv
// Two-requester round-robin packet arbiter feeding a registered 64-bit MAC TX
// interface, with an enforced idle gap after each eop and per-requester packet counters.
module xge_tx_arbiter #(
  parameter int IDLE_GAP = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             arb_en,
  input  logic             req0_val,
  input  logic             req0_sop,
  input  logic             req0_eop,
  input  logic [2:0]       req0_mod,
  input  logic [63:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_val,
  input  logic             req1_sop,
  input  logic             req1_eop,
  input  logic [2:0]       req1_mod,
  input  logic [63:0]      req1_data,
  output logic             req1_ready,
  input  logic             pkt_tx_full,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic [63:0]      pkt_tx_data,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e                  state_q;
  logic [1:0]              grant_q;
  logic                    last_q;
  logic                    first_q;
  logic [3:0]              gap_q;
  logic                    tx_val_q, tx_sop_q, tx_eop_q;
  logic [2:0]              tx_mod_q;
  logic [63:0]             tx_data_q;
  logic [1:0][CNT_W-1:0]   cnt_q;
  logic                    perr_q;

  logic [1:0]              val, sop, eop, sreq, drop, rdy;
  logic [1:0][2:0]         mod;
  logic [1:0][63:0]        data;
  logic                    sel, win, xacc;

  assign val  = {req1_val,  req0_val};
  assign sop  = {req1_sop,  req0_sop};
  assign eop  = {req1_eop,  req0_eop};
  assign mod  = {req1_mod,  req0_mod};
  assign data = {req1_data, req0_data};

  assign sreq = val & sop;
  assign sel  = grant_q[1];
  // On a tie the requester that did not own the previous packet wins.
  assign win  = (&sreq) ? ~last_q : sreq[1];

  // Stray mid-packet words seen in IDLE are swallowed (req0 first) so they cannot stall a requester.
  always_comb begin
    drop    = 2'b00;
    drop[0] = (state_q == IDLE) && val[0] && !sop[0];
    drop[1] = (state_q == IDLE) && val[1] && !sop[1] && !drop[0];
    rdy     = 2'b00;
    for (int n = 0; n < 2; n++)
      rdy[n] = reset_156m25_n &&
               (drop[n] || ((state_q == XFER) && grant_q[n] && !pkt_tx_full));
  end

  assign xacc = (state_q == XFER) && val[sel] && rdy[sel];

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      first_q   <= 1'b0;
      gap_q     <= 4'd0;
      tx_val_q  <= 1'b0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_mod_q  <= 3'd0;
      tx_data_q <= 64'd0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      tx_val_q <= 1'b0;
      tx_sop_q <= 1'b0;
      tx_eop_q <= 1'b0;
      perr_q   <= (|drop) || (xacc && sop[sel] && !first_q);
      case (state_q)
        IDLE: begin
          if (arb_en && (|sreq)) begin
            grant_q <= win ? 2'b10 : 2'b01;
            first_q <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (xacc) begin
            tx_val_q  <= 1'b1;
            tx_sop_q  <= sop[sel] && first_q;
            tx_eop_q  <= eop[sel];
            tx_mod_q  <= eop[sel] ? mod[sel] : 3'd0;
            tx_data_q <= data[sel];
            first_q   <= 1'b0;
            if (eop[sel]) begin
              grant_q <= 2'b00;
              last_q  <= sel;
              if (cnt_q[sel] != {CNT_W{1'b1}})
                cnt_q[sel] <= cnt_q[sel] + 1'b1;
              if (IDLE_GAP == 0) begin
                state_q <= IDLE;
              end else begin
                state_q <= GAP;
                gap_q   <= 4'(IDLE_GAP - 1);
              end
            end
          end
        end
        GAP: begin
          if (gap_q == 4'd0) state_q <= IDLE;
          else               gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready  = rdy[0];
  assign req1_ready  = rdy[1];
  assign pkt_tx_val  = tx_val_q;
  assign pkt_tx_sop  = tx_sop_q;
  assign pkt_tx_eop  = tx_eop_q;
  assign pkt_tx_mod  = tx_mod_q;
  assign pkt_tx_data = tx_data_q;
  assign grant       = grant_q;
  assign pkt_cnt0    = cnt_q[0];
  assign pkt_cnt1    = cnt_q[1];
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Scoreboard bench for xge_tx_arbiter: packets are queued per requester, a monitor
// checks every forwarded word, arbitration fairness, ready rules and packet counts.
`timescale 1ns/1ps
module tb_xge_tx_arbiter;
  localparam int IDLE_GAP = 1;
  localparam int CNT_W    = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] data;
  } word_t;

  logic             clk = 1'b0, rst_n = 1'b0, arb_en = 1'b0, full = 1'b0;
  logic [1:0]       rv = 2'b00, rs = 2'b00, re = 2'b00, rr;
  logic [2:0]       rm [2];
  logic [63:0]      rd [2];
  logic             tx_val, tx_sop, tx_eop, perr;
  logic [2:0]       tx_mod;
  logic [63:0]      tx_data;
  logic [1:0]       grant;
  logic [CNT_W-1:0] cnt0, cnt1;

  xge_tx_arbiter #(.IDLE_GAP(IDLE_GAP), .CNT_W(CNT_W)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .arb_en(arb_en),
    .req0_val(rv[0]), .req0_sop(rs[0]), .req0_eop(re[0]), .req0_mod(rm[0]),
    .req0_data(rd[0]), .req0_ready(rr[0]),
    .req1_val(rv[1]), .req1_sop(rs[1]), .req1_eop(re[1]), .req1_mod(rm[1]),
    .req1_data(rd[1]), .req1_ready(rr[1]),
    .pkt_tx_full(full), .pkt_tx_val(tx_val), .pkt_tx_sop(tx_sop), .pkt_tx_eop(tx_eop),
    .pkt_tx_mod(tx_mod), .pkt_tx_data(tx_data), .grant(grant),
    .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .proto_err(perr)
  );

  always #5 clk = ~clk;

  word_t       src_q [2][$];
  word_t       exp_q [2][$];
  int          checks = 0, errors = 0, cyc = 0, perr_cnt = 0;
  bit          drv_en = 0, bubbles = 0, full_rand = 0, full_force = 0, arb_rand = 0;
  bit          acc_last = 0;
  int          acc_src = 0;
  int          model_cnt [2] = '{0, 0};
  bit          last_win = 1;
  logic [1:0]  prev_vsop = 2'b00, prev_grant = 2'b00;
  logic        prev_arb = 1'b0;
  int          log_cyc [$];
  bit          log_src [$], log_sop [$], log_eop [$];
  logic [63:0] log_data [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_src.delete(); log_sop.delete(); log_eop.delete(); log_data.delete();
  endtask

  task automatic push_word(input int r, input bit s, input bit e, input logic [2:0] m,
                           input logic [63:0] d);
    word_t w, x;
    w.sop = s; w.eop = e; w.mod = m; w.data = d;
    src_q[r].push_back(w);
    x = w;
    if (!e) x.mod = 3'd0;
    exp_q[r].push_back(x);
  endtask

  task automatic load_pkt(input int r, input int len, input logic [2:0] emod);
    for (int i = 0; i < len; i++)
      push_word(r, i == 0, i == len - 1, (i == len - 1) ? emod : 3'($urandom),
                {$urandom, $urandom});
  endtask

  function automatic int pending();
    return src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size();
  endfunction

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (pending() != 0 && n < maxc) begin step(); n++; end
    step(); step();
    chk("drain_timeout", 64'(pending()), 64'd0);
  endtask

  // Requester drivers: present the head word of each queue after every rising edge.
  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      for (int r = 0; r < 2; r++) begin
        if (src_q[r].size() > 0 && !(bubbles && $urandom_range(0, 3) == 0)) begin
          rv[r] = 1'b1; rs[r] = src_q[r][0].sop; re[r] = src_q[r][0].eop;
          rm[r] = src_q[r][0].mod; rd[r] = src_q[r][0].data;
        end else begin
          rv[r] = 1'b0;
        end
      end
      full = full_force || (full_rand && $urandom_range(0, 3) == 0);
      if (arb_rand) arb_en = ($urandom_range(0, 4) != 0);
    end
  end

  // Monitor: anything accepted from the owner must appear on pkt_tx one cycle later.
  always @(negedge clk) begin : mon
    word_t e;
    bit    w;
    cyc++;
    chk("tx_val_latency", 64'(tx_val), 64'(acc_last));
    if (tx_val && acc_last) begin
      if (exp_q[acc_src].size() == 0) begin
        chk("tx_unexpected_word", 64'(exp_q[acc_src].size()), 64'd1);
      end else begin
        e = exp_q[acc_src].pop_front();
        chk("tx_ctrl", 64'({tx_sop, tx_eop, tx_mod}), 64'({e.sop, e.eop, e.mod}));
        chk("tx_data", tx_data, e.data);
        log_cyc.push_back(cyc); log_src.push_back(acc_src[0]);
        log_sop.push_back(tx_sop); log_eop.push_back(tx_eop); log_data.push_back(tx_data);
      end
    end
    if (perr) perr_cnt++;
    chk("grant_onehot", 64'(grant == 2'b11), 64'd0);
    if (prev_grant == 2'b00 && grant != 2'b00) begin
      w = grant[1];
      chk("grant_needs_arb_en", 64'(prev_arb), 64'd1);
      chk("grant_needs_sop", 64'(prev_vsop[w]), 64'd1);
      if (&prev_vsop) chk("round_robin", 64'(w), 64'(!last_win));
      last_win = w;
    end
    if (drv_en)
      for (int r = 0; r < 2; r++)
        chk($sformatf("ready_rule%0d", r), 64'(rr[r]), 64'(grant[r] && !full));
    acc_last = 0;
    for (int r = 0; r < 2; r++) begin
      if (rv[r] && rr[r] && grant[r]) begin
        acc_last = 1; acc_src = r;
        if (drv_en && src_q[r].size() > 0) begin
          e = src_q[r].pop_front();
          if (e.eop && model_cnt[r] < CMAX) model_cnt[r]++;
        end
      end
    end
    prev_vsop  = rv & rs;
    prev_arb   = arb_en;
    prev_grant = grant;
  end

  initial begin : main
    int n, mx, p0, r;
    logic [1:0] exp_g;
    rm[0] = 3'd0; rm[1] = 3'd0; rd[0] = 64'd0; rd[1] = 64'd0;
    rv = 2'b10; rs = 2'b00;
    #7;
    chk("rst_tx_val", 64'(tx_val), 64'd0);
    chk("rst_tx_sop_eop", 64'({tx_sop, tx_eop}), 64'd0);
    chk("rst_tx_mod", 64'(tx_mod), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_cnt", 64'({cnt0, cnt1}), 64'd0);
    chk("rst_perr", 64'(perr), 64'd0);
    chk("rst_ready", 64'(rr), 64'd0);
    rv = 2'b00;
    step(); rst_n = 1'b1; arb_en = 1'b1; drv_en = 1;

    // Both requesters start a 3-word packet together.
    clear_log();
    load_pkt(0, 3, 3'd4); load_pkt(1, 3, 3'd4);
    wait_drain(100);
    chk("t030_words", 64'(log_cyc.size()), 64'd6);
    if (log_cyc.size() == 6) begin
      chk("t030_first_src", 64'(log_src[0]), 64'd0);
      chk("t030_second_src", 64'(log_src[3]), 64'd1);
      chk("t030_eop_to_sop", 64'(log_cyc[3] - log_cyc[2]), 64'(2 + IDLE_GAP));
    end
    chk("t030_cnt0", 64'(cnt0), 64'd1);
    chk("t030_cnt1", 64'(cnt1), 64'd1);

    // Backpressure for 4 cycles in the middle of an 8-word packet.
    clear_log();
    load_pkt(0, 8, 3'($urandom));
    for (n = 0; src_q[0].size() > 5 && n < 50; n++) step();
    chk("t031_wait", 64'(src_q[0].size()), 64'd5);
    full_force = 1;
    repeat (5) @(posedge clk);
    full_force = 0;
    wait_drain(100);
    mx = 0;
    for (int i = 1; i < log_cyc.size(); i++)
      if (log_cyc[i] - log_cyc[i-1] > mx) mx = log_cyc[i] - log_cyc[i-1];
    chk("t031_words", 64'(log_cyc.size()), 64'd8);
    chk("t031_max_gap", 64'(mx), 64'd5);

    // Stray non-sop word in IDLE.
    clear_log();
    drv_en = 0; p0 = perr_cnt;
    rv[1] = 1'b1; rs[1] = 1'b0; re[1] = 1'b0; rd[1] = {$urandom, $urandom};
    @(negedge clk);
    chk("t032_ready1", 64'(rr[1]), 64'd1);
    chk("t032_ready0", 64'(rr[0]), 64'd0);
    step();
    rv[1] = 1'b0;
    chk("t032_perr", 64'(perr), 64'd1);
    repeat (3) step();
    chk("t032_perr_once", 64'(perr_cnt - p0), 64'd1);
    chk("t032_grant", 64'(grant), 64'd0);
    chk("t032_no_tx", 64'(log_cyc.size()), 64'd0);
    drv_en = 1;

    // Single-word packet.
    clear_log();
    push_word(0, 1'b1, 1'b1, 3'd0, 64'hDEADBEEF_01234567);
    wait_drain(50);
    chk("t033_words", 64'(log_cyc.size()), 64'd1);
    if (log_cyc.size() == 1) begin
      chk("t033_sop_eop", 64'({log_sop[0], log_eop[0]}), 64'd3);
      chk("t033_data", log_data[0], 64'hDEADBEEF_01234567);
    end

    // arb_en gating.
    clear_log();
    arb_en = 1'b0;
    load_pkt(0, 2, 3'($urandom)); load_pkt(1, 2, 3'($urandom));
    repeat (4) step();
    chk("t035_no_grant", 64'(grant), 64'd0);
    chk("t035_no_tx", 64'(log_cyc.size()), 64'd0);
    exp_g = last_win ? 2'b01 : 2'b10;
    arb_en = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t035_grant", 64'(grant), 64'(exp_g));
    wait_drain(100);

    // Randomised traffic with bubbles, backpressure and arb_en toggling.
    bubbles = 1; full_rand = 1; arb_rand = 1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 1);
      if (src_q[r].size() < 12) load_pkt(r, $urandom_range(1, 5), 3'($urandom));
      repeat ($urandom_range(0, 5)) step();
    end
    arb_rand = 0; full_rand = 0; arb_en = 1'b1;
    wait_drain(3000);
    chk("rand_cnt0", 64'(cnt0), 64'(model_cnt[0]));
    chk("rand_cnt1", 64'(cnt1), 64'(model_cnt[1]));
    bubbles = 0;

    // Reset during word 2 of a 5-word packet.
    clear_log();
    load_pkt(0, 5, 3'($urandom));
    for (n = 0; src_q[0].size() > 3 && n < 50; n++) step();
    chk("t034_wait", 64'(src_q[0].size()), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t034_tx_val", 64'(tx_val), 64'd0);
    chk("t034_tx_ctrl", 64'({tx_sop, tx_eop, tx_mod}), 64'd0);
    chk("t034_tx_data", tx_data, 64'd0);
    chk("t034_grant", 64'(grant), 64'd0);
    chk("t034_cnt", 64'({cnt0, cnt1}), 64'd0);
    chk("t034_ready", 64'(rr), 64'd0);
    src_q[0].delete(); src_q[1].delete(); exp_q[0].delete(); exp_q[1].delete();
    acc_last = 0; model_cnt[0] = 0; model_cnt[1] = 0; last_win = 1;
    step(); step();
    rst_n = 1'b1;
    clear_log();
    load_pkt(0, 3, 3'($urandom));
    wait_drain(100);
    chk("t034_words", 64'(log_cyc.size()), 64'd3);
    if (log_cyc.size() == 3) chk("t034_sop", 64'(log_sop[0]), 64'd1);
    chk("t034_cnt0", 64'(cnt0), 64'(model_cnt[0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
